// File: rtl/qupls_ptable_mem_responder.sv
// ---------------------------------------------------------------------------
// qupls_ptable_mem_responder
//
// FTA 128-bit bus responder that serves page-table-entry reads and writes
// out of an on-chip table RAM. Requests are accepted one per clock, travel
// through a fixed-latency pipe, and are returned in acceptance order through
// a small response FIFO. A credit count covering pipe + FIFO guarantees the
// FIFO can always absorb what leaves the pipe; when no credit is left the
// request is answered with a combinational retry.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset (RAM contents are kept)
//   ftas_req   bus request (cyc, stb, we, sel, padr, data1, tid used)
//   ftas_resp  bus response (ack, rty, tid, dat, adr; other fields 0)
//   resp_stall response-bus arbiter withholds the slot this cycle
//   busy       registered: outstanding transaction count is nonzero
// ---------------------------------------------------------------------------

package fta_bus_pkg;

   typedef logic [12:0] fta_tranid_t;

   typedef struct packed {
      logic         cyc;
      logic         stb;
      logic         we;
      logic [15:0]  sel;
      logic [31:0]  padr;
      logic [127:0] data1;
      fta_tranid_t  tid;
   } fta_cmd_request128_t;

   typedef struct packed {
      logic         ack;
      logic         rty;
      logic         err;
      fta_tranid_t  tid;
      logic [31:0]  adr;
      logic [127:0] dat;
   } fta_cmd_response128_t;

endpackage

module qupls_ptable_mem_responder
   import fta_bus_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2  = 10,
   parameter logic [31:0] BASE_ADDR   = 32'hFFF80000,
   parameter logic [31:0] ADDR_MASK   = 32'hFFFFC000,
   parameter int unsigned LATENCY     = 2,
   parameter int unsigned RESPQ_DEPTH = 4
)(
   input  logic                 clk,
   input  logic                 rst,
   input  fta_cmd_request128_t  ftas_req,
   output fta_cmd_response128_t ftas_resp,
   input  logic                 resp_stall,
   output logic                 busy
);

   localparam int unsigned LINES = 1 << DEPTH_LOG2;
   localparam int unsigned CW    = $clog2(RESPQ_DEPTH + 1);
   localparam int unsigned PW    = (RESPQ_DEPTH > 1) ? $clog2(RESPQ_DEPTH) : 1;

   typedef struct packed {
      fta_tranid_t  tid;
      logic [31:0]  adr;
      logic         we;
   } pipe_ent_t;

   typedef struct packed {
      fta_tranid_t  tid;
      logic [31:0]  adr;
      logic [127:0] dat;
   } resp_ent_t;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RESPQ_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // storage
   logic [127:0]          mem [LINES];
   pipe_ent_t             pipe_q [LATENCY];
   logic [LATENCY-1:0]    pipe_v;
   logic [127:0]          rd_dat_q;
   resp_ent_t             fifo_q [RESPQ_DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [CW-1:0]         fifo_cnt;
   logic [CW-1:0]         out_cnt;

   // registered response fields
   logic                  ack_q;
   fta_tranid_t           tid_q;
   logic [31:0]           adr_q;
   logic [127:0]          dat_q;

   // control
   logic                  cs;
   logic                  room;
   logic                  accept;
   logic                  push;
   logic                  pop;
   logic                  fifo_empty;
   logic                  fifo_wr;
   logic                  fifo_rd;
   logic [CW-1:0]         out_nxt;
   logic [DEPTH_LOG2-1:0] req_idx;
   logic [DEPTH_LOG2-1:0] rd_idx;
   resp_ent_t             push_ent;
   resp_ent_t             head_ent;

   assign cs = ftas_req.cyc & ftas_req.stb &
               ((ftas_req.padr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
   assign req_idx    = ftas_req.padr[DEPTH_LOG2+3:4];
   assign push       = pipe_v[LATENCY-1];
   assign fifo_empty = (fifo_cnt == '0);
   // An entry leaving the pipe into an empty FIFO may be popped directly.
   assign pop        = (!fifo_empty || push) && !resp_stall;
   assign room       = (out_cnt < CW'(RESPQ_DEPTH)) ||
                       ((out_cnt == CW'(RESPQ_DEPTH)) && pop);
   assign accept     = cs & room;
   assign fifo_wr    = push & ~(fifo_empty & pop);
   assign fifo_rd    = pop & ~fifo_empty;
   assign out_nxt    = out_cnt + CW'(accept) - CW'(pop);

   // RAM read is taken one clock before pipe exit, so rd_dat_q always
   // lines up with the entry sitting in the last pipe stage.
   generate
      if (LATENCY == 1) begin : g_rd_at_accept
         assign rd_idx = req_idx;
      end else begin : g_rd_in_pipe
         assign rd_idx = pipe_q[LATENCY-2].adr[DEPTH_LOG2+3:4];
      end
   endgenerate

   always_comb begin
      push_ent     = '0;
      push_ent.tid = pipe_q[LATENCY-1].tid;
      push_ent.adr = pipe_q[LATENCY-1].adr;
      push_ent.dat = pipe_q[LATENCY-1].we ? '0 : rd_dat_q;
   end

   assign head_ent = fifo_empty ? push_ent : fifo_q[rd_ptr];

   // Table RAM: byte-lane writes on accept, synchronous read for the pipe.
   always_ff @(posedge clk) begin
      if (accept && ftas_req.we) begin
         for (int unsigned i = 0; i < 16; i++) begin
            if (ftas_req.sel[i])
               mem[req_idx][i*8 +: 8] <= ftas_req.data1[i*8 +: 8];
         end
      end
      rd_dat_q <= mem[rd_idx];
   end

   // Latency pipe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_v <= '0;
         for (int unsigned i = 0; i < LATENCY; i++)
            pipe_q[i] <= '0;
      end else begin
         pipe_v[0]     <= accept;
         pipe_q[0].tid <= ftas_req.tid;
         pipe_q[0].adr <= ftas_req.padr;
         pipe_q[0].we  <= ftas_req.we;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   // Response FIFO storage
   always_ff @(posedge clk) begin
      if (fifo_wr)
         fifo_q[wr_ptr] <= push_ent;
   end

   // FIFO pointers and credit accounting
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fifo_cnt <= '0;
         out_cnt  <= '0;
         busy     <= 1'b0;
      end else begin
         if (fifo_wr)
            wr_ptr <= ptr_inc(wr_ptr);
         if (fifo_rd)
            rd_ptr <= ptr_inc(rd_ptr);
         fifo_cnt <= fifo_cnt + CW'(fifo_wr) - CW'(fifo_rd);
         out_cnt  <= out_nxt;
         busy     <= (out_nxt != '0);
      end
   end

   // Registered response; fields are zero whenever ack is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_q <= 1'b0;
         tid_q <= '0;
         adr_q <= '0;
         dat_q <= '0;
      end else if (pop) begin
         ack_q <= 1'b1;
         tid_q <= head_ent.tid;
         adr_q <= head_ent.adr;
         dat_q <= head_ent.dat;
      end else begin
         ack_q <= 1'b0;
         tid_q <= '0;
         adr_q <= '0;
         dat_q <= '0;
      end
   end

   always_comb begin
      ftas_resp     = '0;
      ftas_resp.ack = ack_q;
      ftas_resp.rty = cs & ~room;
      ftas_resp.tid = tid_q;
      ftas_resp.adr = adr_q;
      ftas_resp.dat = dat_q;
   end

endmodule

// File: tb/tb_qupls_ptable_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_qupls_ptable_mem_responder
//
// Drives qupls_ptable_mem_responder one clock at a time and compares every
// cycle's outputs against a transaction-level reference: a queue of accepted
// transactions, each becoming poppable LATENCY clocks after acceptance, and a
// line-indexed copy of the table RAM.
// ---------------------------------------------------------------------------
module tb_qupls_ptable_mem_responder;
   import fta_bus_pkg::*;

   localparam int unsigned DL2       = 10;
   localparam logic [31:0] BASE_ADDR = 32'hFFF80000;
   localparam logic [31:0] ADDR_MASK = 32'hFFFFC000;
   localparam int unsigned LAT       = 2;
   localparam int unsigned QD        = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   fta_cmd_request128_t  req;
   fta_cmd_response128_t resp;
   logic                 resp_stall;
   logic                 busy;

   always #5 clk = ~clk;

   qupls_ptable_mem_responder #(
      .DEPTH_LOG2  (DL2),
      .BASE_ADDR   (BASE_ADDR),
      .ADDR_MASK   (ADDR_MASK),
      .LATENCY     (LAT),
      .RESPQ_DEPTH (QD)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .ftas_req   (req),
      .ftas_resp  (resp),
      .resp_stall (resp_stall),
      .busy       (busy)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int unsigned  rdy;   // first cycle in which it may be popped
      int unsigned  smp;   // cycle whose RAM state a read returns
      logic         we;
      fta_tranid_t  tid;
      logic [31:0]  adr;
      logic [127:0] dat;
   } txn_t;

   typedef struct {
      int unsigned  at;
      fta_tranid_t  tid;
      logic [127:0] dat;
   } ack_t;

   txn_t         q[$];
   ack_t         ack_log[$];
   logic [127:0] mm [int];
   int unsigned  cyc_n     = 0;
   logic         exp_ack   = 1'b0;
   fta_tranid_t  exp_tid   = '0;
   logic [31:0]  exp_adr   = '0;
   logic [127:0] exp_dat   = '0;
   logic         exp_busy  = 1'b0;
   logic         last_rty;

   function automatic int line_of(input logic [31:0] a);
      return int'(a[DL2+3:4]);
   endfunction

   function automatic logic [127:0] init_pat(input int i);
      logic [31:0] w;
      w = 32'hC0DE0000 + 32'(i);
      return {w, ~w, w, ~w};
   endfunction

   // One clock: check outputs mid-cycle, then advance the model across the edge.
   task automatic step();
      logic        cs_m, pop_m, room_m, acc_m;
      int unsigned sz;
      txn_t        t;
      logic [127:0] line;
      @(negedge clk);
      cs_m   = req.cyc && req.stb && ((req.padr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
      sz     = q.size();
      pop_m  = !resp_stall && sz != 0 && q[0].rdy <= cyc_n;
      room_m = (sz < QD) || (sz == QD && pop_m);
      acc_m  = cs_m && room_m;
      last_rty = resp.rty;
      chk("rty",  resp.rty, cs_m && !room_m);
      chk("ack",  resp.ack, exp_ack);
      chk("tid",  resp.tid, exp_tid);
      chk("adr",  resp.adr, exp_adr);
      chk("dat",  resp.dat, exp_dat);
      chk("busy", busy,     exp_busy);
      if (resp.ack === 1'b1)
         ack_log.push_back('{at: cyc_n, tid: resp.tid, dat: resp.dat});
      if (pop_m) begin
         t = q.pop_front();
         exp_ack = 1'b1; exp_tid = t.tid; exp_adr = t.adr; exp_dat = t.dat;
      end else begin
         exp_ack = 1'b0; exp_tid = '0; exp_adr = '0; exp_dat = '0;
      end
      if (acc_m)
         q.push_back('{rdy: cyc_n + LAT, smp: cyc_n + LAT - 1, we: req.we,
                       tid: req.tid, adr: req.padr, dat: '0});
      foreach (q[i])
         if (!q[i].we && q[i].smp == cyc_n)
            q[i].dat = mm[line_of(q[i].adr)];
      if (acc_m && req.we) begin
         line = mm[line_of(req.padr)];
         for (int b = 0; b < 16; b++)
            if (req.sel[b]) line[b*8 +: 8] = req.data1[b*8 +: 8];
         mm[line_of(req.padr)] = line;
      end
      exp_busy = (q.size() != 0);
      cyc_n++;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [15:0] sel, input logic [31:0] padr,
                        input logic [127:0] data, input fta_tranid_t tid);
      req       = '0;
      req.cyc   = 1'b1;
      req.stb   = 1'b1;
      req.we    = we;
      req.sel   = sel;
      req.padr  = padr;
      req.data1 = data;
      req.tid   = tid;
   endtask

   task automatic idle(input int n);
      req = '0;
      for (int i = 0; i < n; i++) step();
   endtask

   int unsigned acc_at;
   logic [31:0] ra;

   initial begin
      rst        = 1'b0;
      resp_stall = 1'b0;
      req        = '0;
      #1;
      chk("rst_ack",  resp.ack, 1'b0);
      chk("rst_busy", busy, 1'b0);
      idle(3);
      rst = 1'b1;
      idle(2);

      // known contents for every line the bench touches
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 16'hFFFF, BASE_ADDR | 32'(i << 4), init_pat(i), 13'(i));
         step();
      end
      drive(1'b1, 16'hFFFF, 32'hFFF83FF0, init_pat(1023), 13'h3FF);
      step();
      idle(10);

      // write then read same line
      ack_log.delete();
      drive(1'b1, 16'hFFFF, 32'hFFF80010, 128'h11223344556677889900AABBCCDDEEFF, 13'd5);
      acc_at = cyc_n;
      step();
      drive(1'b0, 16'hFFFF, 32'hFFF80010, '0, 13'd6);
      step();
      idle(8);
      chk("wr_rd_n", ack_log.size(), 2);
      if (ack_log.size() >= 2) begin
         chk("wr_tid",  ack_log[0].tid, 13'd5);
         chk("wr_dat",  ack_log[0].dat, '0);
         chk("wr_lat",  ack_log[0].at - acc_at, 3);
         chk("rd_tid",  ack_log[1].tid, 13'd6);
         chk("rd_dat",  ack_log[1].dat, 128'h11223344556677889900AABBCCDDEEFF);
      end

      // byte lanes
      ack_log.delete();
      drive(1'b1, 16'hFFFF, 32'hFFF80020, '1, 13'd7);  step();
      drive(1'b1, 16'h00F0, 32'hFFF80020, '0, 13'd8);  step();
      drive(1'b0, 16'hFFFF, 32'hFFF80020, '0, 13'd9);  step();
      idle(8);
      chk("lane_n", ack_log.size(), 3);
      if (ack_log.size() >= 3)
         chk("lane_dat", ack_log[2].dat, 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF);

      // stall until full, fifth held under retry, then pop-and-push
      ack_log.delete();
      resp_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 16'hFFFF, 32'hFFF80030, '0, 13'(20 + i));
         step();
      end
      drive(1'b0, 16'hFFFF, 32'hFFF80030, '0, 13'd24);
      step();
      chk("full_rty", last_rty, 1'b1);
      for (int i = 0; i < 3; i++) step();
      resp_stall = 1'b0;
      step();
      chk("pushpop_rty", last_rty, 1'b0);
      idle(10);
      chk("full_n", ack_log.size(), 5);
      foreach (ack_log[i])
         chk("full_tid", ack_log[i].tid, 13'(20 + i));

      // address decode: outside window ignored
      ack_log.delete();
      drive(1'b1, 16'hFFFF, 32'hFFF7FFF0, 128'hDEAD, 13'd30);
      step();
      chk("dec_rty", last_rty, 1'b0);
      drive(1'b0, 16'hFFFF, 32'hFFF83FF0, '0, 13'd31);
      step();
      idle(8);
      chk("dec_n", ack_log.size(), 1);
      if (ack_log.size() >= 1)
         chk("dec_dat", ack_log[0].dat, init_pat(1023));

      // reset with reads in flight
      resp_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 16'hFFFF, 32'hFFF80040, '0, 13'(40 + i));
         step();
      end
      req = '0;
      rst = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_ack",  resp.ack, 1'b0);
      q.delete();
      exp_ack = 1'b0; exp_tid = '0; exp_adr = '0; exp_dat = '0; exp_busy = 1'b0;
      resp_stall = 1'b0;
      idle(2);
      rst = 1'b1;
      ack_log.delete();
      idle(6);
      chk("post_rst_n", ack_log.size(), 0);
      drive(1'b0, 16'hFFFF, 32'hFFF80010, '0, 13'd50);
      step();
      idle(6);
      chk("post_rst_rd_n", ack_log.size(), 1);
      if (ack_log.size() >= 1)
         chk("post_rst_dat", ack_log[0].dat, 128'h11223344556677889900AABBCCDDEEFF);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         resp_stall = ($urandom_range(0, 99) < 35);
         if ($urandom_range(0, 99) < 15) begin
            req = '0;
         end else begin
            ra = ($urandom_range(0, 7) == 0) ? 32'h3FF0 : 32'($urandom_range(0, 15) << 4);
            ra = ra | 32'($urandom_range(0, 15));
            ra = ($urandom_range(0, 9) == 0) ? (32'hFFF70000 | ra) : (BASE_ADDR | ra);
            drive($urandom_range(0, 99) < 40, 16'($urandom),
                  ra, {$urandom, $urandom, $urandom, $urandom}, 13'($urandom));
         end
         step();
      end
      resp_stall = 1'b0;
      idle(20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/qupls_ptable_mem_responder.md
Name: qupls_ptable_mem_responder

Overview:
- FTA 128-bit bus responder that serves page-table-entry reads and writes from an on-chip table RAM.
- Sits on the bus opposite the hardware table walker's master port.
- Accepts one request per clock and returns tid-tagged responses in order after a fixed pipeline latency.
- Signals retry when its response buffer cannot take another transaction.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM lines; each line is 128 bits (default 16 KiB).
- BASE_ADDR, 32'hFFF80000, physical base of the table window.
- ADDR_MASK, 32'hFFFFC000, bits compared against BASE_ADDR for select.
- LATENCY, 2, clocks from accept to entry in the response FIFO (range 1..4).
- RESPQ_DEPTH, 4, response FIFO entries; also the outstanding-transaction credit limit.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- ftas_req  in  fta_cmd_request128_t  bus request; uses cyc, stb, we, sel[15:0], padr, data1, tid.
- ftas_resp  out  fta_cmd_response128_t  bus response; drives ack, rty, tid, dat, adr; all other fields are 0.
- resp_stall  in  1  response-bus arbiter withholds the slot this cycle.
- busy  out  1  outstanding count is nonzero.

Behaviour:
- Select (combinational): cs = cyc & stb & ((padr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)).
- Line index: padr[DEPTH_LOG2+3:4]. padr[3:0] is carried to the response unchanged.
- Credits: outstanding = entries in the latency pipe + FIFO occupancy.
  - room = (outstanding < RESPQ_DEPTH), or (outstanding == RESPQ_DEPTH and a FIFO pop occurs this cycle).
- Retry:
  - ftas_resp.rty is combinational: cs & ~room.
  - No state changes on a retried request. The master holds the request and re-presents it.
- Accept (cs & room):
  - Write: byte lanes where sel[i]=1 update RAM line byte i from data1 in the same clock.
  - Every accepted request enters the latency pipe with {tid, padr, we}.
- Read data is sampled LATENCY-1 clocks after accept, so a read accepted on the clock after a write to the same line returns the written data.
- Reads and writes both produce a response; write responses have dat=0.
- Pipe exit: after LATENCY clocks the entry is pushed into the FIFO. Credit accounting guarantees the FIFO is never full at push.
- Pop: when the FIFO is non-empty and resp_stall=0, pop the head and register it to ftas_resp next clock.
  - ack=1, tid, dat, adr=padr, all for exactly one clock.
  - ack=0 otherwise. dat, tid and adr are 0 when ack=0.
- Bypass: an entry pushed into an empty FIFO can be popped the same clock.
  - Minimum accept-to-ack latency is LATENCY+1 clocks (3 at default).
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- Ordering: responses leave strictly in acceptance order; tid is never reordered or dropped.
- Unselected requests: ignored, no rty, no ack.
- Reset (rst=0, asynchronous):
  - Pipe, FIFO and counters are cleared.
  - Outputs go to ack=0, rty=0, tid=0, dat=0, adr=0, busy=0.
  - RAM contents are not cleared.
  - Transactions in flight when reset asserts are discarded and produce no ack.
- busy = (outstanding != 0), registered.

Test Plan:
- Write/read: write padr=FFF80010, sel=16'hFFFF, data1=128'h1122...FF, tid=5; then read the same address with tid=6 → two acks in order, tid 5 with dat=0, then tid 6 with dat=128'h1122...FF; first ack 3 clocks after accept.
- Byte lanes: write FFF80020 with all-ones data, then sel=16'h00F0 with data1=0 → read returns 128'hFFFF...FF00000000FF...FF, i.e. bytes 4-7 are zero and all other bytes are FF.
- Stall/full: hold resp_stall=1 and issue 5 reads on consecutive clocks → first 4 accepted, 5th sees rty=1 while held; release stall → acks for the first 4 tids in order, then the 5th is accepted and its ack follows.
- Pop-and-push: FIFO full and stall released in the same clock as a new request → request accepted with rty=0, no ack lost.
- Address decode: request at padr=FFF7FFF0 → no rty, no ack, RAM unchanged.
- Reset mid-flight: assert rst=0 with 3 reads outstanding → ack never asserts for them; busy=0; after release, a read of a previously written line returns the pre-reset data.
